// File: rtl/dmem_dump_sequencer.sv
// dmem_dump_sequencer
// Owns the data-memory port and shares it between the MEM pipeline stage and a
// debug dump engine. The engine walks WORDS consecutive words starting at
// BASE_ADDR and streams each one over a valid/ready handshake. It holds
// stop_debug high to freeze the pipeline while a dump runs.
module dmem_dump_sequencer #(
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter int          WORDS     = 32,
   parameter logic [1:0]  LEN_WORD  = 2'b11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  pipe_rw,
   input  logic [31:0] pipe_addr,
   input  logic [31:0] pipe_wdata,
   input  logic [1:0]  pipe_length,
   output logic [1:0]  mem_rw,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [1:0]  mem_length,
   input  logic [31:0] mem_rdata,
   input  logic        dump_start,
   input  logic        dump_abort,
   output logic        stop_debug,
   output logic [31:0] dbg_data,
   output logic        dbg_valid,
   input  logic        dbg_ready,
   output logic [10:0] dump_count,
   output logic        dump_done
);

   localparam logic [1:0]  RW_IDLE   = 2'b00;
   localparam logic [1:0]  RW_READ   = 2'b10;
   // Byte address of the final word of a dump; wraps like addr_cnt does.
   localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (WORDS - 1));

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DRAIN = 3'd1,
      S_READ  = 3'd2,
      S_WAIT  = 3'd3,
      S_SEND  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   // Registered state and outputs.
   state_t      r_state;
   logic [31:0] r_addr_cnt;
   logic        r_stop_debug;
   logic        r_dbg_valid;
   logic [31:0] r_dbg_data;
   logic [10:0] r_dump_count;
   logic        r_dump_done;

   // Next-state values computed combinationally.
   state_t      w_state_next;
   logic [31:0] w_addr_cnt_next;
   logic        w_stop_debug_next;
   logic        w_dbg_valid_next;
   logic [31:0] w_dbg_data_next;
   logic [10:0] w_dump_count_next;
   logic        w_dump_done_next;

   logic        w_handshake;
   logic        w_abort;
   logic        w_last_word;

   assign w_handshake = r_dbg_valid && dbg_ready;
   assign w_last_word = (r_addr_cnt == LAST_ADDR);
   // Abort only acts while a dump is in progress; DONE always completes.
   assign w_abort     = dump_abort &&
                        ((r_state == S_DRAIN) || (r_state == S_READ) ||
                         (r_state == S_WAIT)  || (r_state == S_SEND));

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_addr_cnt   <= BASE_ADDR;
         r_stop_debug <= 1'b0;
         r_dbg_valid  <= 1'b0;
         r_dbg_data   <= 32'h0;
         r_dump_count <= 11'd0;
         r_dump_done  <= 1'b0;
      end else begin
         r_addr_cnt   <= w_addr_cnt_next;
         r_stop_debug <= w_stop_debug_next;
         r_dbg_valid  <= w_dbg_valid_next;
         r_dbg_data   <= w_dbg_data_next;
         r_dump_count <= w_dump_count_next;
         r_dump_done  <= w_dump_done_next;
      end
   end

   // Next-state logic for the dump engine, abort overriding everything else.
   always_comb begin
      w_state_next      = r_state;
      w_addr_cnt_next   = r_addr_cnt;
      w_stop_debug_next = r_stop_debug;
      w_dbg_valid_next  = r_dbg_valid;
      w_dbg_data_next   = r_dbg_data;
      w_dump_count_next = r_dump_count;
      w_dump_done_next  = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (dump_start) begin
               w_state_next      = S_DRAIN;
               w_stop_debug_next = 1'b1;
               w_addr_cnt_next   = BASE_ADDR;
               w_dump_count_next = 11'd0;
            end
         end
         S_DRAIN: begin
            // The MEM-stage access of this cycle still reaches the memory.
            w_state_next = S_READ;
         end
         S_READ: begin
            w_state_next = S_WAIT;
         end
         S_WAIT: begin
            // Read data returns one cycle after the address was presented.
            w_dbg_data_next  = mem_rdata;
            w_dbg_valid_next = 1'b1;
            w_state_next     = S_SEND;
         end
         S_SEND: begin
            if (w_handshake) begin
               w_dbg_valid_next  = 1'b0;
               w_dump_count_next = r_dump_count + 11'd1;
               if (w_last_word) begin
                  w_state_next = S_DONE;
               end else begin
                  w_addr_cnt_next = r_addr_cnt + 32'd4;
                  w_state_next    = S_READ;
               end
            end
         end
         S_DONE: begin
            w_dump_done_next  = 1'b1;
            w_stop_debug_next = 1'b0;
            w_state_next      = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase

      // A cancelled word is not counted and no completion pulse is raised.
      if (w_abort) begin
         w_state_next      = S_IDLE;
         w_stop_debug_next = 1'b0;
         w_dbg_valid_next  = 1'b0;
         w_dbg_data_next   = r_dbg_data;
         w_dump_count_next = r_dump_count;
         w_addr_cnt_next   = r_addr_cnt;
         w_dump_done_next  = 1'b0;
      end
   end

   // Memory-port mux: pipeline owns the port in IDLE/DRAIN, the engine reads in READ.
   always_comb begin
      mem_rw     = RW_IDLE;
      mem_addr   = 32'h0;
      mem_wdata  = 32'h0;
      mem_length = 2'b00;
      case (r_state)
         S_IDLE, S_DRAIN: begin
            mem_rw     = pipe_rw;
            mem_addr   = pipe_addr;
            mem_wdata  = pipe_wdata;
            mem_length = pipe_length;
         end
         S_READ: begin
            mem_rw     = RW_READ;
            mem_addr   = r_addr_cnt;
            mem_length = LEN_WORD;
         end
         default: begin
            mem_rw = RW_IDLE;
         end
      endcase
   end

   assign stop_debug = r_stop_debug;
   assign dbg_data   = r_dbg_data;
   assign dbg_valid  = r_dbg_valid;
   assign dump_count = r_dump_count;
   assign dump_done  = r_dump_done;

endmodule

// File: tb/tb_dmem_dump_sequencer.sv
// Bench for dmem_dump_sequencer: a behavioural data memory, a reference copy of
// memory contents kept by the stimulus, and a scoreboard queue of expected
// dump words that a negedge monitor pops on every accepted word.
module tb_dmem_dump_sequencer;

   localparam logic [31:0] BASE = 32'h0;
   localparam int          W    = 4;
   localparam logic [1:0]  LW   = 2'b11;

   logic        clk;
   logic        rst;
   logic [1:0]  pipe_rw;
   logic [31:0] pipe_addr;
   logic [31:0] pipe_wdata;
   logic [1:0]  pipe_length;
   logic [1:0]  mem_rw;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [1:0]  mem_length;
   logic [31:0] mem_rdata;
   logic        dump_start;
   logic        dump_abort;
   logic        stop_debug;
   logic [31:0] dbg_data;
   logic        dbg_valid;
   logic        dbg_ready;
   logic [10:0] dump_count;
   logic        dump_done;

   dmem_dump_sequencer #(
      .BASE_ADDR (BASE),
      .WORDS     (W),
      .LEN_WORD  (LW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pipe_rw     (pipe_rw),
      .pipe_addr   (pipe_addr),
      .pipe_wdata  (pipe_wdata),
      .pipe_length (pipe_length),
      .mem_rw      (mem_rw),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_length  (mem_length),
      .mem_rdata   (mem_rdata),
      .dump_start  (dump_start),
      .dump_abort  (dump_abort),
      .stop_debug  (stop_debug),
      .dbg_data    (dbg_data),
      .dbg_valid   (dbg_valid),
      .dbg_ready   (dbg_ready),
      .dump_count  (dump_count),
      .dump_done   (dump_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory seen by the DUT: registered read, write on mem_rw=01.
   logic [31:0] ram [0:255];
   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 32'h0;
      mem_rdata = 32'h0;
   end
   always @(posedge clk) begin
      if (mem_rw == 2'b10) mem_rdata <= ram[mem_addr[9:2]];
      else if (mem_rw == 2'b01) ram[mem_addr[9:2]] <= mem_wdata;
   end

   // Reference contents: what memory must hold given the writes the pipeline issued.
   logic [31:0] ref_mem [0:255];
   initial for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

   int          cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q [$];
   int          hs_times [$];
   int          hs_total = 0;
   int          done_total = 0;
   int          start_cyc = 0;
   logic        prev_stop = 1'b0;
   logic [31:0] mon_exp;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'(a[9:2]);
   endfunction

   // Monitor: port-safety checks during a dump and scoreboard pops on accepted words.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (prev_stop && stop_debug) begin
            chk("dump_no_write", 32'(mem_rw == 2'b01), 32'd0);
            if (mem_rw == 2'b10) begin
               chk("dump_rd_length", 32'(mem_length), 32'(LW));
               chk("dump_rd_wdata", mem_wdata, 32'd0);
            end
         end
         if (dbg_valid && dbg_ready && !dump_abort) begin
            hs_total++;
            hs_times.push_back(cyc);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_word: got 0x%08h, required no word", dbg_data);
            end else begin
               mon_exp = exp_q.pop_front();
               chk("dump_word", dbg_data, mon_exp);
               $display("word accepted #%0d data=0x%08h expected=0x%08h", hs_total, dbg_data, mon_exp);
            end
         end
         if (dump_done) done_total++;
      end
      prev_stop = stop_debug;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic nsample();
      @(negedge clk);
      #1;
   endtask

   task automatic pipe_idle();
      pipe_rw     = 2'b00;
      pipe_addr   = 32'h0;
      pipe_wdata  = 32'h0;
      pipe_length = 2'b00;
   endtask

   task automatic pipe_write(input logic [31:0] a, input logic [31:0] d);
      pipe_rw     = 2'b01;
      pipe_addr   = a;
      pipe_wdata  = d;
      pipe_length = LW;
      ref_mem[widx(a)] = d;
      tick();
      pipe_idle();
   endtask

   // Called in IDLE at posedge+1; returns in READ at posedge+1.
   task automatic start_dump(input bit drain_wr, input logic [31:0] drain_val);
      if (drain_wr) begin
         pipe_rw     = 2'b01;
         pipe_addr   = BASE + 32'd8;
         pipe_wdata  = ~drain_val;
         pipe_length = LW;
         ref_mem[widx(BASE + 32'd8)] = ~drain_val;
      end
      dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      start_cyc  = cyc;
      pipe_idle();
      if (drain_wr) begin
         pipe_rw     = 2'b01;
         pipe_addr   = BASE + 32'd8;
         pipe_wdata  = drain_val;
         pipe_length = LW;
         ref_mem[widx(BASE + 32'd8)] = drain_val;
      end
      for (int i = 0; i < W; i++) exp_q.push_back(ref_mem[widx(BASE + 32'(4 * i))]);
      tick();
      pipe_idle();
   endtask

   task automatic wait_done(input string name, input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         nsample();
         if (dump_done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      chk(name, 32'(seen), 32'd1);
   endtask

   task automatic wait_hs(input string name, input int target, input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         nsample();
         if (hs_total >= target) begin
            seen = 1'b1;
            break;
         end
      end
      chk(name, 32'(seen), 32'd1);
   endtask

   task automatic wait_valid(input string name, input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         nsample();
         if (dbg_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      chk(name, 32'(seen), 32'd1);
   endtask

   initial begin
      #1_000_000;
      n_checks++;
      n_errors++;
      $display("FAIL watchdog: got timeout, required completion");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      int          done_base;
      int          hs_base;
      int          lat;
      logic [31:0] held;
      bit          finished;

      rst = 1'b0;
      dump_start = 1'b0;
      dump_abort = 1'b0;
      dbg_ready  = 1'b0;
      pipe_idle();

      // Reset state
      repeat (3) tick();
      nsample();
      chk("rst_stop_debug", 32'(stop_debug), 32'd0);
      chk("rst_dbg_valid", 32'(dbg_valid), 32'd0);
      chk("rst_dbg_data", dbg_data, 32'd0);
      chk("rst_dump_count", 32'(dump_count), 32'd0);
      chk("rst_dump_done", 32'(dump_done), 32'd0);
      tick();
      rst = 1'b1;

      // Idle passthrough
      pipe_rw = 2'b01; pipe_addr = 32'h10; pipe_wdata = 32'hDEADBEEF; pipe_length = 2'b10;
      #1;
      chk("pass_rw", 32'(mem_rw), 32'h1);
      chk("pass_addr", mem_addr, 32'h10);
      chk("pass_wdata", mem_wdata, 32'hDEADBEEF);
      chk("pass_length", 32'(mem_length), 32'h2);
      chk("pass_stop_debug", 32'(stop_debug), 32'd0);
      ref_mem[widx(32'h10)] = 32'hDEADBEEF;
      tick();
      pipe_rw = 2'b10; pipe_addr = 32'h10; pipe_wdata = 32'h0; pipe_length = LW;
      tick();
      pipe_idle();
      chk("pass_readback", mem_rdata, ref_mem[widx(32'h10)]);

      // Full dump with dbg_ready held
      pipe_write(BASE + 32'd0,  32'h11);
      pipe_write(BASE + 32'd4,  32'h22);
      pipe_write(BASE + 32'd8,  32'h33);
      pipe_write(BASE + 32'd12, 32'h44);
      dbg_ready = 1'b1;
      hs_times.delete();
      done_base = done_total;
      start_dump(1'b0, 32'h0);
      $display("dump started: full, ready held");
      wait_done("full_done_seen", 200);
      lat = cyc - start_cyc;
      chk("full_latency", 32'(lat), 32'(5 + 3 * (W - 1)));
      chk("full_dump_count", 32'(dump_count), 32'(W));
      chk("full_stop_released", 32'(stop_debug), 32'd0);
      chk("full_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("full_word_total", 32'(hs_times.size()), 32'(W));
      for (int k = 0; k < hs_times.size(); k++)
         chk("full_word_spacing", 32'(hs_times[k] - ((k == 0) ? start_cyc : hs_times[k - 1])), 32'd3);
      tick();
      nsample();
      chk("full_done_one_cycle", 32'(dump_done), 32'd0);
      repeat (3) tick();
      chk("full_done_once", 32'(done_total), 32'(done_base + 1));

      // Backpressure on word 1
      dbg_ready = 1'b1;
      hs_base = hs_total;
      start_dump(1'b0, 32'h0);
      $display("dump started: backpressure on word 1");
      wait_hs("bp_word0_seen", hs_base + 1, 50);
      tick();
      dbg_ready = 1'b0;
      wait_valid("bp_word1_valid", 50);
      held = dbg_data;
      for (int k = 0; k < 7; k++) begin
         if (k != 0) nsample();
         chk("bp_valid_held", 32'(dbg_valid), 32'd1);
         chk("bp_data_held", dbg_data, held);
         chk("bp_mem_idle", 32'(mem_rw), 32'd0);
      end
      tick();
      dbg_ready = 1'b1;
      wait_done("bp_done_seen", 200);
      chk("bp_dump_count", 32'(dump_count), 32'(W));
      chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
      tick();

      // Abort in SEND of word 2, same cycle as a handshake
      dbg_ready = 1'b1;
      hs_base = hs_total;
      done_base = done_total;
      start_dump(1'b0, 32'h0);
      $display("dump started: abort on word 2");
      wait_hs("ab_word1_seen", hs_base + 2, 50);
      tick();
      dbg_ready = 1'b0;
      wait_valid("ab_word2_valid", 50);
      tick();
      dbg_ready  = 1'b1;
      dump_abort = 1'b1;
      tick();
      dump_abort = 1'b0;
      dbg_ready  = 1'b0;
      nsample();
      chk("ab_dbg_valid", 32'(dbg_valid), 32'd0);
      chk("ab_stop_debug", 32'(stop_debug), 32'd0);
      chk("ab_dump_count", 32'(dump_count), 32'd2);
      chk("ab_words_left", 32'(exp_q.size()), 32'(W - 2));
      exp_q.delete();
      repeat (5) tick();
      chk("ab_no_done", 32'(done_total), 32'(done_base));

      // Pipeline write completing during DRAIN
      dbg_ready = 1'b1;
      start_dump(1'b1, 32'hCAFE0008);
      $display("dump started: drain write to 0x8");
      wait_done("drain_done_seen", 200);
      chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("drain_ram_value", ref_mem[widx(BASE + 32'd8)], 32'hCAFE0008);
      tick();

      // Reset asserted during WAIT
      dbg_ready = 1'b1;
      start_dump(1'b0, 32'h0);
      $display("dump started: reset during WAIT");
      tick();
      rst = 1'b0;
      pipe_rw = 2'b10; pipe_addr = 32'h10; pipe_length = LW;
      tick();
      nsample();
      chk("mrst_stop_debug", 32'(stop_debug), 32'd0);
      chk("mrst_dbg_valid", 32'(dbg_valid), 32'd0);
      chk("mrst_dbg_data", dbg_data, 32'd0);
      chk("mrst_dump_count", 32'(dump_count), 32'd0);
      chk("mrst_dump_done", 32'(dump_done), 32'd0);
      chk("mrst_mux_rw", 32'(mem_rw), 32'h2);
      chk("mrst_mux_addr", mem_addr, 32'h10);
      exp_q.delete();
      tick();
      rst = 1'b1;
      pipe_idle();
      dbg_ready = 1'b0;
      tick();

      // Randomized dumps with random backpressure and blocked pipeline traffic
      for (int it = 0; it < 8; it++) begin
         int nwr;
         nwr = $urandom_range(0, 5);
         for (int j = 0; j < nwr; j++)
            pipe_write({22'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
         done_base = done_total;
         start_dump(1'b0, 32'h0);
         $display("dump started: random run %0d", it);
         finished = 1'b0;
         for (int c = 0; c < 1000; c++) begin
            dbg_ready   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
               0:       pipe_rw = 2'b00;
               1:       pipe_rw = 2'b01;
               default: pipe_rw = 2'b10;
            endcase
            pipe_addr   = {22'h0, 4'($urandom_range(0, 15)), 2'b00};
            pipe_wdata  = $urandom;
            pipe_length = 2'($urandom_range(0, 3));
            tick();
            if (!stop_debug) begin
               finished = 1'b1;
               break;
            end
         end
         pipe_idle();
         dbg_ready = 1'b0;
         chk("rnd_finished", 32'(finished), 32'd1);
         nsample();
         chk("rnd_done_once", 32'(done_total), 32'(done_base + 1));
         chk("rnd_dump_count", 32'(dump_count), 32'(W));
         chk("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
         tick();
      end

      // Memory must hold exactly the pipeline's idle-time writes
      for (int i = 0; i < 16; i++) begin
         pipe_rw = 2'b10; pipe_addr = 32'(4 * i); pipe_length = LW;
         tick();
         chk("final_readback", mem_rdata, ref_mem[i]);
      end
      pipe_idle();
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
